// File: rtl/gpio_quad_decoder_if.sv
// Encoder pin inputs, host controls and decoder status for one axis.
interface gpio_quad_decoder_if #(
  parameter int unsigned COUNT_W = 32
);
  logic               ENC_A;
  logic               ENC_B;
  logic               ENC_Z;
  logic               CLR;
  logic               QERR_CLR;
  logic               IDX_ACK;
  logic [COUNT_W-1:0] POS;
  logic               DIR;
  logic               CNT_STB;
  logic               QERR;
  logic [COUNT_W-1:0] IDX_POS;
  logic               IDX_VALID;

  modport master (
    output ENC_A, ENC_B, ENC_Z, CLR, QERR_CLR, IDX_ACK,
    input  POS, DIR, CNT_STB, QERR, IDX_POS, IDX_VALID
  );

  modport slave (
    input  ENC_A, ENC_B, ENC_Z, CLR, QERR_CLR, IDX_ACK,
    output POS, DIR, CNT_STB, QERR, IDX_POS, IDX_VALID
  );
endinterface

// File: rtl/gpio_quad_decoder.sv
// X4 quadrature decoder with 2-flop synchronizers and per-input glitch filters.
// Define QUAD_INDEX_EN to enable index (Z) position capture.
module gpio_quad_decoder #(
  parameter int unsigned COUNT_W    = 32,
  parameter int unsigned FILTER_LEN = 4
) (
  input logic                CLOCK_50,
  input logic                RESET_N,
  gpio_quad_decoder_if.slave bus
);

`ifdef QUAD_INDEX_EN
  localparam int unsigned NumIn = 3;
`else
  localparam int unsigned NumIn = 2;
`endif

  // Bit 1 = A, bit 0 = B, bit 2 = Z when index capture is built in.
  logic [NumIn-1:0]      pin_raw;
  logic [NumIn-1:0]      sync1_q, sync2_q;
  logic [NumIn-1:0]      filt_q, filt_d;
  logic [NumIn-1:0][7:0] cnt_q, cnt_d;

`ifdef QUAD_INDEX_EN
  assign pin_raw = {bus.ENC_Z, bus.ENC_A, bus.ENC_B};
`else
  assign pin_raw = {bus.ENC_A, bus.ENC_B};
`endif

  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < NumIn; i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == 8'(FILTER_LEN - 1)) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  logic [1:0]         ab_prev_q;
  logic [1:0]         ab_cur;
  logic               step_up, step_dn, step_err;
  logic [COUNT_W-1:0] pos_q, pos_d;
  logic               dir_q, dir_d;
  logic               stb_q, stb_d;
  logic               qerr_q, qerr_d;

  assign ab_cur = filt_q[1:0];

  always_comb begin
    step_up  = 1'b0;
    step_dn  = 1'b0;
    step_err = 1'b0;
    case ({ab_prev_q, ab_cur})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_up  = 1'b1;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_dn  = 1'b1;
      4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: step_err = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    stb_d  = 1'b0;
    qerr_d = qerr_q & ~bus.QERR_CLR;
    if (step_up) begin
      pos_d = pos_q + 1'b1;
      dir_d = 1'b1;
      stb_d = 1'b1;
    end else if (step_dn) begin
      pos_d = pos_q - 1'b1;
      dir_d = 1'b0;
      stb_d = 1'b1;
    end else if (step_err) begin
      qerr_d = 1'b1;
    end
    // Clear drops a coincident count but keeps its strobe and direction.
    if (bus.CLR) pos_d = '0;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      filt_q    <= '0;
      cnt_q     <= '0;
      ab_prev_q <= 2'b00;
      pos_q     <= '0;
      dir_q     <= 1'b0;
      stb_q     <= 1'b0;
      qerr_q    <= 1'b0;
    end else begin
      sync1_q   <= pin_raw;
      sync2_q   <= sync1_q;
      filt_q    <= filt_d;
      cnt_q     <= cnt_d;
      ab_prev_q <= ab_cur;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      stb_q     <= stb_d;
      qerr_q    <= qerr_d;
    end
  end

  assign bus.POS     = pos_q;
  assign bus.DIR     = dir_q;
  assign bus.CNT_STB = stb_q;
  assign bus.QERR    = qerr_q;

`ifdef QUAD_INDEX_EN
  logic               z_prev_q;
  logic               z_rise;
  logic [COUNT_W-1:0] idx_pos_q, idx_pos_d;
  logic               idx_valid_q, idx_valid_d;

  assign z_rise = filt_q[2] & ~z_prev_q;

  always_comb begin
    idx_pos_d   = idx_pos_q;
    idx_valid_d = idx_valid_q & ~bus.IDX_ACK;
    // Capture the pre-update count; a coincident ack loses to the new capture.
    if (z_rise) begin
      idx_pos_d   = pos_q;
      idx_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      z_prev_q    <= 1'b0;
      idx_pos_q   <= '0;
      idx_valid_q <= 1'b0;
    end else begin
      z_prev_q    <= filt_q[2];
      idx_pos_q   <= idx_pos_d;
      idx_valid_q <= idx_valid_d;
    end
  end

  assign bus.IDX_POS   = idx_pos_q;
  assign bus.IDX_VALID = idx_valid_q;
`else
  assign bus.IDX_POS   = '0;
  assign bus.IDX_VALID = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_quad_decoder.sv
// Directed bench: a 32-bit decoder for counting, filter, error, index and reset,
// plus an 8-bit, FILTER_LEN=1 instance for signed wrap-around.
module tb_gpio_quad_decoder;

  localparam int HOLD  = 10;
  localparam int HOLD8 = 5;

  logic CLOCK_50 = 1'b0;
  logic RESET_N  = 1'b0;

  always #10 CLOCK_50 = ~CLOCK_50;

  gpio_quad_decoder_if #(.COUNT_W(32)) bus ();
  gpio_quad_decoder_if #(.COUNT_W(8))  b8 ();

  gpio_quad_decoder #(.COUNT_W(32), .FILTER_LEN(4)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .bus      (bus.slave)
  );

  gpio_quad_decoder #(.COUNT_W(8), .FILTER_LEN(1)) dut8 (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .bus      (b8.slave)
  );

  typedef struct {
    logic        a;
    logic        b;
    logic        clr;
    logic [31:0] pos;
    logic        dir;
    int          stb;
    logic        qerr;
  } vec_t;

  vec_t vecs[19];
  int   n_pass  = 0;
  int   n_total = 0;
  int   stb_total = 0;

  // Strobe counter samples 2 ns after each rising edge.
  always @(posedge CLOCK_50) begin
    #2;
    if (bus.CNT_STB) stb_total++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic apply(input int i);
    int s0;
    s0 = stb_total;
    bus.ENC_A = vecs[i].a;
    bus.ENC_B = vecs[i].b;
    bus.CLR   = vecs[i].clr;
    wait_clk(HOLD);
    bus.CLR = 1'b0;
    check($sformatf("v%0d pos", i), bus.POS, vecs[i].pos);
    check($sformatf("v%0d dir", i), 32'(bus.DIR), 32'(vecs[i].dir));
    check($sformatf("v%0d stb", i), 32'(stb_total - s0), 32'(vecs[i].stb));
    check($sformatf("v%0d qerr", i), 32'(bus.QERR), 32'(vecs[i].qerr));
  endtask

  task automatic check_idx(input string name, input logic [31:0] p, input logic v);
`ifdef QUAD_INDEX_EN
    check({name, " idx_pos"}, bus.IDX_POS, p);
    check({name, " idx_valid"}, 32'(bus.IDX_VALID), 32'(v));
`else
    check({name, " idx_pos"}, bus.IDX_POS, 32'd0);
    check({name, " idx_valid"}, 32'(bus.IDX_VALID), 32'd0);
`endif
  endtask

  task automatic check_reset(input string name);
    check({name, " pos"}, bus.POS, 32'd0);
    check({name, " dir"}, 32'(bus.DIR), 32'd0);
    check({name, " stb"}, 32'(bus.CNT_STB), 32'd0);
    check({name, " qerr"}, 32'(bus.QERR), 32'd0);
    check({name, " idx_pos"}, bus.IDX_POS, 32'd0);
    check({name, " idx_valid"}, 32'(bus.IDX_VALID), 32'd0);
  endtask

  initial begin
    logic [1:0] seq [4];
    int s0;

    //           a     b     clr   pos     dir   stb qerr
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'd1, 1'b1, 1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'd2, 1'b1, 1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'd3, 1'b1, 1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'd4, 1'b1, 1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'd5, 1'b1, 1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'd6, 1'b1, 1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'd7, 1'b1, 1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'd8, 1'b1, 1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'd7, 1'b0, 1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'd6, 1'b0, 1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 32'd5, 1'b0, 1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'd4, 1'b0, 1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 32'd4, 1'b0, 0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 32'd0, 1'b1, 1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'd1, 1'b1, 1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 32'd2, 1'b1, 1, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 32'd3, 1'b1, 1, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 32'd4, 1'b1, 1, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 32'd1, 1'b1, 1, 1'b0};

    seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00;

    bus.ENC_A = 0; bus.ENC_B = 0; bus.ENC_Z = 0;
    bus.CLR = 0; bus.QERR_CLR = 0; bus.IDX_ACK = 0;
    b8.ENC_A = 0; b8.ENC_B = 0; b8.ENC_Z = 0;
    b8.CLR = 0; b8.QERR_CLR = 0; b8.IDX_ACK = 0;

    wait_clk(3);
    check_reset("reset");
    RESET_N = 1'b1;
    wait_clk(2);

    // Eight up-steps then three down-steps.
    for (int i = 0; i <= 10; i++) apply(i);

    // Three-clock glitch on A must be rejected.
    s0 = stb_total;
    bus.ENC_A = 1'b0;
    wait_clk(3);
    bus.ENC_A = 1'b1;
    wait_clk(HOLD);
    check("glitch pos", bus.POS, 32'd5);
    check("glitch stb", 32'(stb_total - s0), 32'd0);

    // Down to 00, then an illegal 00->11 jump.
    for (int i = 11; i <= 12; i++) apply(i);

    bus.QERR_CLR = 1'b1;
    wait_clk(1);
    bus.QERR_CLR = 1'b0;
    wait_clk(1);
    check("qerr_clr", 32'(bus.QERR), 32'd0);

    // Up-step under CLR, then resume counting.
    for (int i = 13; i <= 16; i++) apply(i);

    // Index capture at POS=3, recapture at POS=4, then acknowledge.
    check_idx("idx none", 32'd0, 1'b0);
    bus.ENC_Z = 1'b1;
    wait_clk(HOLD);
    check_idx("idx first", 32'd3, 1'b1);
    bus.ENC_Z = 1'b0;
    wait_clk(HOLD);
    apply(17);
    bus.ENC_Z = 1'b1;
    wait_clk(HOLD);
    check_idx("idx second", 32'd4, 1'b1);
    bus.IDX_ACK = 1'b1;
    wait_clk(1);
    bus.IDX_ACK = 1'b0;
    wait_clk(1);
    check_idx("idx ack", 32'd4, 1'b0);
    bus.ENC_Z = 1'b0;
    wait_clk(HOLD);

    // Reset in the middle of a filter interval for an up-step 01->00.
    bus.ENC_A = 1'b0;
    bus.ENC_B = 1'b0;
    wait_clk(2);
    RESET_N = 1'b0;
    wait_clk(1);
    RESET_N = 1'b1;
    check_reset("midreset");
    s0 = stb_total;
    wait_clk(HOLD);
    check("post reset pos", bus.POS, 32'd0);
    check("post reset stb", 32'(stb_total - s0), 32'd0);
    apply(18);

    // Signed wrap-around on the 8-bit instance.
    for (int k = 0; k < 127; k++) begin
      b8.ENC_A = seq[k % 4][1];
      b8.ENC_B = seq[k % 4][0];
      wait_clk(HOLD8);
    end
    check("w8 max", 32'(b8.POS), 32'h7F);
    b8.ENC_A = seq[3][1];
    b8.ENC_B = seq[3][0];
    wait_clk(HOLD8);
    check("w8 wrap up", 32'(b8.POS), 32'h80);
    check("w8 dir up", 32'(b8.DIR), 32'd1);
    b8.ENC_A = seq[2][1];
    b8.ENC_B = seq[2][0];
    wait_clk(HOLD8);
    check("w8 wrap down", 32'(b8.POS), 32'h7F);
    check("w8 dir down", 32'(b8.DIR), 32'd0);
    check("w8 qerr", 32'(b8.QERR), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gpio_quad_decoder.md
Name: gpio_quad_decoder

Overview:
Input-side counterpart to the GPIO output drive on the DE2 board. It samples encoder feedback on GPIO_0 inputs: phases A, B and index Z from a machine axis. The block synchronizes and glitch-filters the inputs, then decodes X4 quadrature into a signed position count with direction, count strobe and error reporting. LinuxCNC host logic reads POS and the status outputs; one instance is used per axis.

Parameters:
COUNT_W, 32, width of the signed position counter (8..32)
FILTER_LEN, 4, number of consecutive stable clocks required before a filtered input changes (1..255)

Ports:
CLOCK_50  in  1  system clock, 50 MHz
RESET_N  in  1  synchronous active-low reset, sampled on rising CLOCK_50
ENC_A  in  1  encoder phase A, asynchronous (GPIO_0 pin)
ENC_B  in  1  encoder phase B, asynchronous (GPIO_0 pin)
ENC_Z  in  1  encoder index, asynchronous (GPIO_0 pin)
CLR  in  1  synchronous clear of POS
QERR_CLR  in  1  clears QERR
IDX_ACK  in  1  clears IDX_VALID
POS  out  COUNT_W  signed position count, two's complement
DIR  out  1  direction of last valid count: 1 = up, 0 = down
CNT_STB  out  1  one-cycle pulse on each valid count
QERR  out  1  sticky illegal-transition flag
IDX_POS  out  COUNT_W  POS captured at index
IDX_VALID  out  1  sticky; IDX_POS holds a new capture

Behaviour:
- Reset (RESET_N=0 at a clock edge): POS=0, DIR=0, CNT_STB=0, QERR=0, IDX_POS=0, IDX_VALID=0. Synchronizers, filter counters and filtered values are 0. Prev-state register {A,B}=00.
- Reset asserted mid-operation takes effect on the next edge and discards any partially counted filter interval.
- Synchronizer: each of A/B/Z passes through 2 flops.
- Filter, per input: 8-bit counter.
  - If synced value equals filtered value: counter = 0.
  - Otherwise counter increments.
  - When counter reaches FILTER_LEN-1 and the input is still different: filtered value takes the synced value and counter = 0.
  - A change lasting fewer than FILTER_LEN clocks is rejected.
  - Latency from pin edge to filtered edge = 2 + FILTER_LEN clocks (±1 for async sampling).
- Decoder: compares filtered {A,B} with prev {A,B} every clock, then prev is updated.
  - Up sequence: 00→10→11→01→00 (A leads). Each step: POS+1, DIR=1, CNT_STB=1 next cycle.
  - Down sequence: reverse order. Each step: POS-1, DIR=0, CNT_STB=1.
  - No change: no count, CNT_STB=0.
  - Both phases change in one clock (00↔11, 10↔01): no count, DIR unchanged, QERR=1.
- Wrap-around: POS wraps modulo 2^COUNT_W (max positive +1 → most negative; most negative −1 → max positive). No saturation, no flag.
- CLR=1: POS=0 next cycle. CLR has priority over a simultaneous count; that count is lost, but CNT_STB still pulses and DIR still updates.
- QERR_CLR=1: QERR=0, unless a new illegal transition occurs in the same cycle, in which case QERR stays 1 (set wins).
- Steady state: POS, DIR, QERR, IDX_POS and IDX_VALID hold their values.

Optional Feature:
QUAD_INDEX_EN
- Defined:
  - A rising edge of filtered Z loads IDX_POS with the POS value of that cycle (before that cycle's count update) and sets IDX_VALID=1.
  - A later index edge overwrites IDX_POS while IDX_VALID stays 1.
  - IDX_ACK=1 clears IDX_VALID; if an index edge occurs in the same cycle, set wins.
- Not defined:
  - ENC_Z is ignored, with no Z synchronizer or filter logic.
  - IDX_POS is tied to 0 and IDX_VALID to 0.
  - Ports remain present.

Test Plan:
1. Reset, FILTER_LEN=4, then drive 8 up-steps (00,10,11,01,00,10,11,01,00), each held 10 clocks → POS=8, DIR=1, exactly 8 CNT_STB pulses, QERR=0.
2. From POS=8, drive 3 down-steps → POS=5, DIR=0. Then a 3-clock glitch on A → POS stays 5, no CNT_STB.
3. Preload POS=0x7FFFFFFF via up-steps (or force), 1 up-step → POS=0x80000000. Then 1 down-step → POS=0x7FFFFFFF.
4. Jump A,B from 00 to 11 simultaneously → QERR=1, POS unchanged. Pulse QERR_CLR → QERR=0. Assert CLR in the same cycle as an up-step → POS=0.
5. With QUAD_INDEX_EN: POS=100, Z rising edge → IDX_POS=100, IDX_VALID=1. Pulse IDX_ACK → IDX_VALID=0. Without the macro: same Z stimulus → IDX_VALID stays 0.
6. Assert RESET_N=0 for 1 clock during an active up-sequence at POS=42 → all outputs return to reset values the next cycle, and counting resumes from 0.
